// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - oversampled SPI slave with command/address decode and burst auto-increment
//
// All logic runs on clk; SPI_SCLK, SPI_MOSI and SPI_SS pass through 2-FF
// synchronisers and SCLK edges are detected on the synchronised copy.
// Optional feature macro: SPI_SLAVE_STATUS_EN (adds the status input,
// shifted out on MISO during the command word).
//
// Ports:
//   clk, rst_n      system clock (>= 4x SCLK), asynchronous active-low reset
//   SPI_SCLK        SPI clock from master (asynchronous)
//   SPI_MOSI        serial data from master
//   SPI_SS          slave select, active-low
//   SPI_MISO        serial data to master, MSb of shift_out (never tristated)
//   status          (SPI_SLAVE_STATUS_EN only) word presented during the command
//   addr            current register address
//   wr_data         last completed write word
//   wr_data_valid   1-clk strobe when wr_data is updated
//   rd_data         read data for addr
//   rd_data_ack     1-clk pulse when rd_data is captured into shift_out
//   busy            synchronised SS active
//   frame_err       1-clk pulse when SS deasserts mid-word
module spi_slave_sync #(
  parameter int unsigned       ADDR_W    = 7,
  parameter int unsigned       DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter logic [ADDR_W-1:0] WRAP_HI   = 7'd11,
  parameter logic [ADDR_W-1:0] WRAP_LO   = 7'd7,
  parameter logic [ADDR_W-1:0] HOLD_ADDR = 7'd15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SPI_SCLK,
  input  logic              SPI_MOSI,
  input  logic              SPI_SS,
`ifdef SPI_SLAVE_STATUS_EN
  input  logic [DATA_W-1:0] status,
`endif
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_data_ack,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned       CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  state_t state, state_nx;

  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic ss_s1, ss_s2, ss_d;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] shift_out;
  logic              write_readn;
  logic              load_skip;
  logic              wr_go, rd_go, wr_inc, rd_inc;

  logic              sclk_rise, sclk_fall, lead, trail;
  logic              ss_fall, ss_rise, active;
  logic              sample_edge, shift_edge, word_last;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] addr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_d  <= CPOL;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
    end else begin
      sclk_s1 <= SPI_SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= SPI_MOSI;
      mosi_s2 <= mosi_s1;
      ss_s1   <= SPI_SS;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign lead        = CPOL ? sclk_fall : sclk_rise;
  assign trail       = CPOL ? sclk_rise : sclk_fall;
  assign ss_fall     = ss_d & ~ss_s2;
  assign ss_rise     = ~ss_d & ss_s2;
  assign active      = (state != IDLE) && !ss_s2;
  assign sample_edge = active && (CPHA ? trail : lead);
  assign shift_edge  = active && (CPHA ? lead : trail);
  assign word_last   = sample_edge && (bit_cnt == LAST);
  assign word        = {shift_in[DATA_W-2:0], mosi_s2};
  assign addr_next   = (addr == WRAP_HI) ? WRAP_LO : addr + 1'b1;

  assign SPI_MISO = shift_out[DATA_W-1];
  assign busy     = ~ss_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ss_rise) begin
      state_nx = IDLE;
    end else if (ss_fall) begin
      state_nx = CMD;
    end else if (state == CMD && word_last) begin
      state_nx = word[DATA_W-1] ? WDATA : RDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      shift_in      <= '0;
      shift_out     <= '0;
      write_readn   <= 1'b0;
      addr          <= '0;
      wr_data       <= '0;
      wr_data_valid <= 1'b0;
      rd_data_ack   <= 1'b0;
      frame_err     <= 1'b0;
      load_skip     <= 1'b0;
      wr_go         <= 1'b0;
      rd_go         <= 1'b0;
      wr_inc        <= 1'b0;
      rd_inc        <= 1'b0;
    end else begin
      wr_data_valid <= 1'b0;
      rd_data_ack   <= 1'b0;
      frame_err     <= 1'b0;
      wr_go         <= 1'b0;
      rd_go         <= 1'b0;
      wr_inc        <= 1'b0;
      rd_inc        <= 1'b0;

      // Completion pipeline: word -> strobe/load -> address increment.
      // It runs regardless of SS so a word finished just before SS rises
      // still produces its strobe.
      if (wr_go) begin
        wr_data       <= shift_in;
        wr_data_valid <= 1'b1;
        wr_inc        <= 1'b1;
      end
      if (rd_go) begin
        shift_out   <= rd_data;
        rd_data_ack <= 1'b1;
        rd_inc      <= 1'b1;
        load_skip   <= 1'b1;
      end
      if (wr_inc || (rd_inc && addr != HOLD_ADDR)) begin
        addr <= addr_next;
      end

      // A sample edge between a load and the next shift edge means the MSb
      // has already been seen by the master, so only an immediately
      // following shift edge is suppressed.
      if (shift_edge) begin
        if (load_skip) load_skip <= 1'b0;
        else           shift_out <= shift_out << 1;
      end

      if (sample_edge) begin
        shift_in  <= word;
        load_skip <= 1'b0;
        bit_cnt   <= word_last ? '0 : bit_cnt + 1'b1;
        if (word_last) begin
          case (state)
            CMD: begin
              write_readn <= word[DATA_W-1];
              addr        <= word[ADDR_W-1:0];
              rd_go       <= ~word[DATA_W-1];
            end
            WDATA:   wr_go <= 1'b1;
            RDATA:   rd_go <= 1'b1;
            default: ;
          endcase
        end
      end

      if (ss_rise) begin
        bit_cnt <= '0;
        if (state != IDLE && bit_cnt != '0) frame_err <= 1'b1;
      end

      if (ss_fall) begin
        bit_cnt   <= '0;
        load_skip <= 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
        shift_out <= status;
`else
        shift_out <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - scoreboard bench for spi_slave_sync in mode 0 and mode 3
module tb_spi_slave_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sclk_gen, sclk_b, mosi, ss_a, ss_b;
  logic       miso_a, miso_b;
  logic [6:0] addr_a, addr_b;
  logic [7:0] wr_data_a, wr_data_b, rd_data_a, rd_data_b;
  logic       wr_valid_a, wr_valid_b, ack_a, ack_b, busy_a, busy_b, ferr_a, ferr_b;

`ifdef SPI_SLAVE_STATUS_EN
  logic [7:0] status = 8'h5A;
  localparam logic [7:0] CMD_RX = 8'h5A;
`else
  localparam logic [7:0] CMD_RX = 8'h00;
`endif

  assign sclk_b    = ~sclk_gen;
  assign rd_data_a = {1'b0, addr_a} + 8'h40;
  assign rd_data_b = {1'b0, addr_b} + 8'h40;

  spi_slave_sync dut_a (
    .clk(clk), .rst_n(rst_n), .SPI_SCLK(sclk_gen), .SPI_MOSI(mosi), .SPI_SS(ss_a),
`ifdef SPI_SLAVE_STATUS_EN
    .status(status),
`endif
    .SPI_MISO(miso_a), .addr(addr_a), .wr_data(wr_data_a), .wr_data_valid(wr_valid_a),
    .rd_data(rd_data_a), .rd_data_ack(ack_a), .busy(busy_a), .frame_err(ferr_a)
  );

  spi_slave_sync #(.CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .SPI_SCLK(sclk_b), .SPI_MOSI(mosi), .SPI_SS(ss_b),
`ifdef SPI_SLAVE_STATUS_EN
    .status(status),
`endif
    .SPI_MISO(miso_b), .addr(addr_b), .wr_data(wr_data_b), .wr_data_valid(wr_valid_b),
    .rd_data(rd_data_b), .rd_data_ack(ack_b), .busy(busy_b), .frame_err(ferr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] wr_exp_a[$];
  logic [6:0]  ack_exp_a[$], ack_exp_b[$], ferr_exp_a[$];
  logic [7:0]  rx_exp[$], rx_act[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a DUT output event appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid_a) begin
        if (wr_exp_a.size() == 0) chk("wr_a_extra", wr_exp_a.size(), 1);
        else begin
          logic [14:0] e;
          e = wr_exp_a.pop_front();
          chk("wr_addr_a", addr_a, e[14:8]);
          chk("wr_data_a", wr_data_a, e[7:0]);
        end
      end
      if (ack_a) begin
        if (ack_exp_a.size() == 0) chk("ack_a_extra", ack_exp_a.size(), 1);
        else chk("ack_addr_a", addr_a, ack_exp_a.pop_front());
      end
      if (ack_b) begin
        if (ack_exp_b.size() == 0) chk("ack_b_extra", ack_exp_b.size(), 1);
        else chk("ack_addr_b", addr_b, ack_exp_b.pop_front());
      end
      if (ferr_a) begin
        if (ferr_exp_a.size() == 0) chk("ferr_a_extra", ferr_exp_a.size(), 1);
        else chk("ferr_addr_a", addr_a, ferr_exp_a.pop_front());
      end
      if (wr_valid_b) chk("wr_b_extra", wr_valid_b, 0);
      if (ferr_b)     chk("ferr_b_extra", ferr_b, 0);
      while (rx_act.size() > 0) begin
        logic [7:0] a;
        a = rx_act.pop_front();
        if (rx_exp.size() == 0) chk("rx_extra", rx_exp.size(), 1);
        else chk("miso_byte", a, rx_exp.pop_front());
      end
    end
  end

  // SPI master: sel=0 drives dut_a in mode 0, sel=1 drives dut_b in mode 3.
  task automatic xfer(input bit sel, input logic [7:0] tx, input int nbits, input bit record);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!sel) begin
        mosi = tx[7-i];
        #40 sclk_gen = 1'b1;
        rx = {rx[6:0], miso_a};
        #40 sclk_gen = 1'b0;
      end else begin
        sclk_gen = 1'b1;
        mosi = tx[7-i];
        #40 sclk_gen = 1'b0;
        rx = {rx[6:0], miso_b};
        #40;
      end
    end
    if (record) rx_act.push_back(rx);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_addr"},    addr_a, 0);
    chk({tag, "_wr_data"}, wr_data_a, 0);
    chk({tag, "_wr_valid"}, wr_valid_a, 0);
    chk({tag, "_ack"},     ack_a, 0);
    chk({tag, "_ferr"},    ferr_a, 0);
    chk({tag, "_busy"},    busy_a, 0);
    chk({tag, "_miso"},    miso_a, 0);
  endtask

  initial begin
    rst_n = 1'b0; sclk_gen = 1'b0; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1;
    #33;
    check_reset_a("rst0");
    chk("rst0_addr_b", addr_b, 0);
    chk("rst0_miso_b", miso_b, 0);
    rst_n = 1'b1;
    #100;

    // Mode 0 write burst with wrap 11 -> 7.
    wr_exp_a.push_back({7'd11, 8'hA1});
    wr_exp_a.push_back({7'd7,  8'hA2});
    wr_exp_a.push_back({7'd8,  8'hA3});
    rx_exp.push_back(CMD_RX);
    ss_a = 1'b0; #100;
    xfer(0, 8'h8B, 8, 1);
    xfer(0, 8'hA1, 8, 0);
    xfer(0, 8'hA2, 8, 0);
    xfer(0, 8'hA3, 8, 0);
    #100 ss_a = 1'b1; #200;

    // Mode 3 read from 5; third ack follows the last dummy byte.
    ack_exp_b.push_back(7'd5);
    ack_exp_b.push_back(7'd6);
    ack_exp_b.push_back(7'd7);
    rx_exp.push_back(CMD_RX);
    rx_exp.push_back(8'h45);
    rx_exp.push_back(8'h46);
    ss_b = 1'b0; #100;
    xfer(1, 8'h05, 8, 1);
    xfer(1, 8'h00, 8, 1);
    xfer(1, 8'h00, 8, 1);
    #100 ss_b = 1'b1; #200;

    // Read at HOLD_ADDR: address never moves.
    for (int i = 0; i < 4; i++) ack_exp_a.push_back(7'd15);
    rx_exp.push_back(CMD_RX);
    for (int i = 0; i < 3; i++) rx_exp.push_back(8'h4F);
    ss_a = 1'b0; #100;
    xfer(0, 8'h0F, 8, 1);
    for (int i = 0; i < 3; i++) xfer(0, 8'h00, 8, 1);
    #100 ss_a = 1'b1; #200;
    chk("hold_addr", addr_a, 15);

    // Abort after 5 bits of a write data byte.
    ferr_exp_a.push_back(7'd2);
    rx_exp.push_back(CMD_RX);
    ss_a = 1'b0; #100;
    xfer(0, 8'h82, 8, 1);
    xfer(0, 8'hA5, 5, 0);
    #100 ss_a = 1'b1; #200;
    chk("abort_addr", addr_a, 2);
    chk("abort_wr_data", wr_data_a, 8'hA3);

    // Async reset in the middle of a read.
    ack_exp_a.push_back(7'd3);
    rx_exp.push_back(CMD_RX);
    ss_a = 1'b0; #100;
    xfer(0, 8'h03, 8, 1);
    xfer(0, 8'h00, 4, 0);
    #7 rst_n = 1'b0;
    #1 check_reset_a("rst_mid");
    ss_a = 1'b1;
    #50 rst_n = 1'b1;
    #100;

    // Normal write after reset.
    wr_exp_a.push_back({7'd1, 8'h33});
    rx_exp.push_back(CMD_RX);
    ss_a = 1'b0; #100;
    xfer(0, 8'h81, 8, 1);
    xfer(0, 8'h33, 8, 0);
    #100 ss_a = 1'b1; #200;
    chk("post_rst_addr", addr_a, 2);

    for (int i = 0; i < 200 && (wr_exp_a.size() + ack_exp_a.size() + ack_exp_b.size()
         + ferr_exp_a.size() + rx_exp.size() + rx_act.size()) != 0; i++) @(posedge clk);
    chk("left_wr_a",   wr_exp_a.size(), 0);
    chk("left_ack_a",  ack_exp_a.size(), 0);
    chk("left_ack_b",  ack_exp_b.size(), 0);
    chk("left_ferr_a", ferr_exp_a.size(), 0);
    chk("left_rx",     rx_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
